alu_rr_arbiter: RTL and testbench

- Shares one 32-bit combinational ALU (ops: add, sub, and, or, srl, sra) between two requesters.
- Round-robin arbitration; operands are registered before being driven to the ALU.
- Result is captured into a register and returned on a single tagged response channel with valid/ready handshake.
- Sits between the control/requester logic and the ALU instance, which is outside this block and connected through the alu_* ports.

---
 rtl/alu_rr_arbiter_pkg.sv | 21 ++
 rtl/alu_rr_arbiter_rr_grant2.sv | 35 +++
 rtl/alu_rr_arbiter.sv | 110 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes and FSM state encodings.
package alu_rr_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/alu_rr_arbiter_rr_grant2.sv
// Combinational two-way grant. Round-robin on last_grant by default;
// ALU_ARB_FIXED_PRIO_EN makes requester 0 always win contention.
module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic any_valid,
    output logic grant
);

    assign any_valid = valid0 | valid1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 1'b0;
        if (!valid0 && valid1) begin
            grant = 1'b1;
        end
    end
`else
    // Under contention the requester that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one external 32-bit ALU between two requesters with a tagged response
// channel. Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority for requester 0.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c
);

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic             id_r;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             any_valid;
    logic             grant;
    logic             accept;

    rr_grant2 u_grant (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .any_valid  (any_valid),
        .grant      (grant)
    );

    assign accept = (state == IDLE) && any_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ALU inputs come straight from the operand registers so they stay stable for the whole op.
    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        rsp_valid  = (state == RESP);
        rsp_data   = res_r;
        rsp_id     = id_r;
        alu_a      = a_r;
        alu_b      = b_r;
        alu_op     = op_r;
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            res_r      <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                id_r       <= grant;
                op_r       <= grant ? req1_op : req0_op;
                a_r        <= grant ? req1_a  : req0_a;
                b_r        <= grant ? req1_b  : req0_b;
            end
            if (state == EXEC) begin
                res_r <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU model on the alu_* ports.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected contention grant order.
module tb_alu_rr_arbiter;
    import alu_rr_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;

    int compared   = 0;
    int mismatched = 0;

    alu_rr_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU stand-in; unused op codes behave as arithmetic shift right.
    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SRL: return a >> b;
            default: return $unsigned($signed(a) >>> b);
        endcase
    endfunction

    assign alu_c = aluModel(alu_op, alu_a, alu_b);

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one op from a single requester, starting and ending at a negedge in IDLE.
    task automatic applyStimulus(input logic id, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input string name);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        checkOutput({name, ".ready_own"},   id ? req1_ready : req0_ready, 1);
        checkOutput({name, ".ready_other"}, id ? req0_ready : req1_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checkOutput({name, ".exec_rsp_valid"}, rsp_valid, 0);
        checkOutput({name, ".exec_ready"}, {req1_ready, req0_ready}, 0);
        checkOutput({name, ".alu_a"},  alu_a, a);
        checkOutput({name, ".alu_b"},  alu_b, b);
        checkOutput({name, ".alu_op"}, alu_op, op);
        @(posedge clk);
        #1;
        checkOutput({name, ".rsp_valid"}, rsp_valid, 1);
        checkOutput({name, ".rsp_data"},  rsp_data, exp);
        checkOutput({name, ".rsp_id"},    rsp_id, id);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic expOrder[4];
    int   waitCount;

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b1;

        vecs[0] = '{1'b0, ALU_ADD, 32'd5,         32'd7,         32'd12,        "add_0"};
        vecs[1] = '{1'b1, ALU_SUB, 32'd3,         32'd5,         32'hFFFFFFFE,  "sub_1"};
        vecs[2] = '{1'b0, ALU_AND, 32'hFF00FF00,  32'h0F0F0F0F,  32'h0F000F00,  "and_0"};
        vecs[3] = '{1'b1, ALU_OR,  32'hFF00FF00,  32'h0F0F0F0F,  32'hFF0FFF0F,  "or_1"};
        vecs[4] = '{1'b0, ALU_SRL, 32'h80000000,  32'd31,        32'h00000001,  "srl_31"};
        vecs[5] = '{1'b0, 3'b111,  32'h80000000,  32'd31,        32'hFFFFFFFF,  "op7_sra"};
        vecs[6] = '{1'b1, ALU_ADD, 32'hFFFFFFFF,  32'd2,         32'h00000001,  "add_wrap"};
        vecs[7] = '{1'b1, ALU_SRL, 32'h80000000,  32'd32,        32'h00000000,  "srl_fullb"};
        vecs[8] = '{1'b0, 3'b110,  32'h80000000,  32'd1,         32'hC0000000,  "op6_sra"};

        // Reset values while reset is held
        @(posedge clk);
        #1;
        checkOutput("rst.rsp_valid", rsp_valid, 0);
        checkOutput("rst.rsp_data",  rsp_data, 0);
        checkOutput("rst.rsp_id",    rsp_id, 0);
        checkOutput("rst.alu_a",     alu_a, 0);
        checkOutput("rst.alu_b",     alu_b, 0);
        checkOutput("rst.alu_op",    alu_op, 0);
        checkOutput("rst.ready",     {req1_ready, req0_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("idle.ready_novalid", {req1_ready, req0_ready}, 0);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // Contention: both held for four ops from a fresh reset
`ifdef ALU_ARB_FIXED_PRIO_EN
        expOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        doReset();
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1;  req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'd10; req1_b = 32'd10;
        for (int i = 0; i < 4; i++) begin
            waitCount = 0;
            while (!rsp_valid && waitCount < 12) begin
                @(negedge clk);
                waitCount++;
            end
            checkOutput($sformatf("rr%0d.rsp_valid", i), rsp_valid, 1);
            checkOutput($sformatf("rr%0d.rsp_id", i), rsp_id, expOrder[i]);
            checkOutput($sformatf("rr%0d.rsp_data", i), rsp_data, expOrder[i] ? 32'd20 : 32'd2);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: response held while req1 waits for IDLE
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = ALU_SRA; req0_a = 32'h80000000; req0_b = 32'd4;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'd1; req1_b = 32'd2;
        #1;
        checkOutput("bp.exec_req1_ready", req1_ready, 0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp%0d.rsp_valid", i), rsp_valid, 1);
            checkOutput($sformatf("bp%0d.rsp_data", i), rsp_data, 32'hF8000000);
            checkOutput($sformatf("bp%0d.rsp_id", i), rsp_id, 0);
            checkOutput($sformatf("bp%0d.req1_ready", i), req1_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp.release_rsp_valid", rsp_valid, 1);
        checkOutput("bp.release_req1_ready", req1_ready, 0);
        @(negedge clk);
        checkOutput("bp.idle_rsp_valid", rsp_valid, 0);
        checkOutput("bp.idle_req1_ready", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp.next_rsp_valid", rsp_valid, 1);
        checkOutput("bp.next_rsp_data", rsp_data, 32'd3);
        checkOutput("bp.next_rsp_id", rsp_id, 1);
        @(posedge clk);
        @(negedge clk);

        // Reset while in EXEC discards the op
        req0_valid = 1'b1; req0_op = ALU_AND; req0_a = 32'hFF00FF00; req0_b = 32'h0F0F0F0F;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rexec.rsp_valid", rsp_valid, 0);
        checkOutput("rexec.rsp_data",  rsp_data, 0);
        checkOutput("rexec.rsp_id",    rsp_id, 0);
        checkOutput("rexec.alu_a",     alu_a, 0);
        checkOutput("rexec.alu_b",     alu_b, 0);
        checkOutput("rexec.alu_op",    alu_op, 0);
        checkOutput("rexec.ready",     {req1_ready, req0_ready}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rexec%0d.no_rsp", i), rsp_valid, 0);
        end
        applyStimulus(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
